// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a common-anode multi-digit 7-segment display.
// Optional leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned DivW = $clog2(REFRESH_DIV);

  logic [DivW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [IdxW-1:0]         scan_idx_q;
  logic                    frame_done_q;
  logic                    tick, last_digit;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic [3:0]              cur_digit;
  logic                    cur_en;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tick       = (div_q == DivW'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // Walk down from the top digit; blanking stops at the first non-zero digit.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above  = zero_above & (shadow_q[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_above;
    end
  end

  assign eff_en = digit_en & ~lz_blank;
`else
  assign eff_en = digit_en;
`endif

  assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];
  assign cur_en    = eff_en[idx_q];

  always_comb begin
    an_d  = cur_en ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_d = cur_en ? hex_decode(cur_digit) : 7'b0000000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      an_q         <= '0;
      seg_q        <= '0;
      scan_idx_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      if (load) begin
        shadow_q <= value;
      end
      an_q         <= an_d;
      seg_q        <= seg_d;
      scan_idx_q   <= idx_q;
      frame_done_q <= tick & last_digit;
    end
  end

  // Internal state is active-high; invert only at the pins.
  assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign an         = ACTIVE_LOW ? ~an_q : an_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues the
// expected pins per clock edge and a monitor pops and compares each cycle.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam bit          AL = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .seg       (seg),
    .an        (an),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          sb_on = 1'b0;
  int          e_cnt = 0;
  logic [15:0] shadow_m = '0;

  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [15:0] hex_vals [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lz_blank(input int k, input logic [15:0] sh);
`ifdef SEG7_LZ_BLANK_EN
    return (k > 0) && ((sh >> (4 * k)) == 16'h0);
`else
    return 1'b0 && (k > 0) && (sh == 16'h0);
`endif
  endfunction

  // Called just after a rising edge: sets inputs for the next edge and queues
  // what the pins must show after that edge.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] en);
    exp_t       x;
    int         slot;
    logic [3:0] d;
    logic [3:0] oh;
    logic [6:0] s;
    bit         on;
    load     = ld;
    value    = v;
    digit_en = en;
    slot = (e_cnt / RD) % ND;
    d    = shadow_m[4*slot +: 4];
    on   = en[slot] && !lz_blank(slot, shadow_m);
    oh   = on ? (4'b0001 << slot) : 4'b0000;
    s    = on ? hex_tab[d] : 7'b0000000;
    x.an  = AL ? ~oh : oh;
    x.seg = AL ? ~s : s;
    x.idx = 2'(slot);
    x.fd  = ((e_cnt + 1) % (ND * RD)) == 0;
    sb_q.push_back(x);
    if (ld) shadow_m = v;
    e_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_inactive(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
    check({tag, "_idx"}, 32'(scan_idx), 32'h0);
  endtask

  // Reset lands between edges; pins must go inactive before any clock.
  task automatic reset_mid_frame();
    @(negedge clk);
    #2;
    rst   = 1'b1;
    load  = 1'b0;
    sb_on = 1'b0;
    sb_q.delete();
    #1;
    check_inactive("async_rst");
    @(posedge clk);
    #1;
    check_inactive("rst_hold");
    rst      = 1'b0;
    e_cnt    = 0;
    shadow_m = '0;
    sb_on    = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      if (sb_on && sb_q.size() > 0) begin
        exp_t x;
        @(negedge clk);
        x = sb_q.pop_front();
        check("an", 32'(an), 32'(x.an));
        check("seg", 32'(seg), 32'(x.seg));
        check("scan_idx", 32'(scan_idx), 32'(x.idx));
        check("frame_done", 32'(frame_done), 32'(x.fd));
      end
    end
  end

  initial begin : driver
    bit          ld;
    logic [15:0] v;
    logic [3:0]  en;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_inactive("reset");
    rst   = 1'b0;
    sb_on = 1'b1;

    step(1'b1, 16'h1234, 4'hF);
    repeat (40) step(1'b0, 16'h0, 4'hF);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, hex_vals[i], 4'hF);
      repeat (16) step(1'b0, 16'h0, 4'hF);
    end

    step(1'b1, 16'h8888, 4'b1010);
    repeat (20) step(1'b0, 16'h0, 4'b1010);

    step(1'b1, 16'h0005, 4'hF);
    while (((e_cnt / RD) % ND) != 0 || (e_cnt % RD) != 1) step(1'b0, 16'h0, 4'hF);
    step(1'b1, 16'h0009, 4'hF);
    repeat (6) step(1'b0, 16'h0, 4'hF);

    step(1'b1, 16'hABCD, 4'hF);
    while (((e_cnt / RD) % ND) != 2 || (e_cnt % RD) != 1) step(1'b0, 16'h0, 4'hF);
    reset_mid_frame();
    repeat (20) step(1'b0, 16'h0, 4'hF);

    step(1'b1, 16'h0070, 4'hF);
    repeat (20) step(1'b0, 16'h0, 4'hF);
    step(1'b1, 16'h0000, 4'hF);
    repeat (20) step(1'b0, 16'h0, 4'hF);

    en = 4'hF;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      if (ld && ($urandom_range(0, 3) == 0)) v = v & 16'h00FF;
      step(ld, v, en);
    end
    load = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
